// File: rtl/lcd_text_formatter_pkg.sv
// Constants shared by the LCD text formatter: ASCII glyphs, line geometry,
// FSM state encoding and the reset line template.
package lcd_text_formatter_pkg;

  localparam int LINE_LEN = 16;

  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_N     = 8'h4E;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_DIGIT = 8'h30;

  // Tens-digit positions; the units digit always sits one position later.
  localparam logic [3:0] POS_A = 4'd2;
  localparam logic [3:0] POS_N = 4'd7;
  localparam logic [3:0] POS_R = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_STORE = 2'd3
  } fmt_state_t;

  // Character shown at a position before any conversion has completed:
  // every operand reads as zero, with the tens digit blanked when lz=0.
  function automatic logic [7:0] template_char(input logic [3:0] pos, input logic lz);
    logic [7:0] ch;
    ch = CH_SP;
    case (pos)
      4'd0:                ch = CH_A;
      4'd5:                ch = CH_N;
      4'd10:               ch = CH_R;
      4'd1, 4'd6, 4'd11:   ch = CH_EQ;
      4'd2, 4'd7, 4'd12:   ch = lz ? CH_DIGIT : CH_SP;
      4'd3, 4'd8, 4'd13:   ch = CH_DIGIT;
      default:             ch = CH_SP;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/lcd_text_formatter_bcd_dabble6.sv
// Serial double-dabble engine: converts a 6-bit binary value into two BCD
// digits, one shift per step pulse; six steps after a load complete a value.
module bcd_dabble6
  import lcd_text_formatter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] bin,
  input  logic       step,
  output logic [3:0] tens,
  output logic [3:0] units
);

  // {tens, units, binary} working register
  logic [13:0] sr;
  logic [3:0]  tens_adj;
  logic [3:0]  units_adj;
  logic [13:0] sr_adj;

  // Add-3 correction of any BCD nibble that would overflow past 9 on the shift
  always_comb begin
    tens_adj  = (sr[13:10] >= 4'd5) ? sr[13:10] + 4'd3 : sr[13:10];
    units_adj = (sr[9:6]   >= 4'd5) ? sr[9:6]   + 4'd3 : sr[9:6];
    sr_adj    = {tens_adj, units_adj, sr[5:0]};
  end

  // Load clears the BCD half; each step applies the correction then shifts left
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= {8'd0, bin};
    end else if (step) begin
      sr <= sr_adj << 1;
    end
  end

  assign tens  = sr[13:10];
  assign units = sr[9:6];

endmodule

// File: rtl/lcd_text_formatter.sv
// Snapshots base/exponent/result on start, converts each to two decimal digits
// through a shared serial engine and fills a 16-character ASCII line buffer.
// buf_valid marks a fully written line so the LCD never shows a partial one.
module lcd_text_formatter
  import lcd_text_formatter_pkg::*;
#(
  parameter int LEADING_ZERO = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] a_val,
  input  logic [5:0] n_val,
  input  logic [5:0] res_val,
  input  logic [3:0] char_addr,
  output logic [7:0] char_data,
  output logic       busy,
  output logic       buf_valid
);

  localparam logic LZ = (LEADING_ZERO != 0);

  fmt_state_t state, state_nxt;
  logic [1:0] k, k_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic       accept;
  logic       done;
  logic       eng_load;
  logic       eng_step;
  logic       store_en;

  logic [5:0] snap_a, snap_n, snap_r;
  logic [5:0] eng_bin;
  logic [3:0] eng_tens, eng_units;
  logic [3:0] pos_t;

  logic [7:0] line_buf [LINE_LEN];

  function automatic logic [7:0] tens_ascii(input logic [3:0] d);
    if (d == 4'd0 && !LZ) return CH_SP;
    return CH_DIGIT + {4'd0, d};
  endfunction

  function automatic logic [7:0] units_ascii(input logic [3:0] d);
    return CH_DIGIT + {4'd0, d};
  endfunction

  // FSM state, operand index and shift counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= 2'd0;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic and engine/buffer control strobes
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    done      = 1'b0;
    eng_load  = 1'b0;
    eng_step  = 1'b0;
    store_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          k_nxt     = 2'd0;
          cnt_nxt   = 3'd0;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        eng_load  = 1'b1;
        cnt_nxt   = 3'd0;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        eng_step = 1'b1;
        if (cnt == 3'd5) begin
          cnt_nxt   = 3'd0;
          state_nxt = ST_STORE;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      ST_STORE: begin
        store_en = 1'b1;
        if (k == 2'd2) begin
          done      = 1'b1;
          k_nxt     = 2'd0;
          state_nxt = ST_IDLE;
        end else begin
          k_nxt     = k + 2'd1;
          state_nxt = ST_LOAD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand and buffer-position selection by operand index
  always_comb begin
    case (k)
      2'd0:    begin eng_bin = snap_a; pos_t = POS_A; end
      2'd1:    begin eng_bin = snap_n; pos_t = POS_N; end
      default: begin eng_bin = snap_r; pos_t = POS_R; end
    endcase
  end

  // Input snapshot, frozen for the whole conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_a <= '0;
      snap_n <= '0;
      snap_r <= '0;
    end else if (accept) begin
      snap_a <= a_val;
      snap_n <= n_val;
      snap_r <= res_val;
    end
  end

  bcd_dabble6 u_dabble (
    .clk   (clk),
    .rst   (rst),
    .load  (eng_load),
    .bin   (eng_bin),
    .step  (eng_step),
    .tens  (eng_tens),
    .units (eng_units)
  );

  // Line buffer: reset to the zero template, digit pairs written on STORE
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINE_LEN; i++) begin
        line_buf[i] <= template_char(4'(i), LZ);
      end
    end else if (store_en) begin
      line_buf[pos_t]        <= tens_ascii(eng_tens);
      line_buf[pos_t + 4'd1] <= units_ascii(eng_units);
    end
  end

  // Registered read port; a same-edge write is seen one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      char_data <= CH_SP;
    end else begin
      char_data <= line_buf[char_addr];
    end
  end

  // Line-complete flag: cleared on an accepted start, set when res is stored
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
    end else if (accept) begin
      buf_valid <= 1'b0;
    end else if (done) begin
      buf_valid <= 1'b1;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_text_formatter.sv
// Bench for lcd_text_formatter: a line-level reference model checked every
// cycle, plus directed scenarios with literal expected lines.
module tb_lcd_text_formatter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] a_val, n_val, res_val;
  logic [3:0] char_addr;
  logic [7:0] char_data, char_data_nz;
  logic       busy, busy_nz;
  logic       buf_valid, buf_valid_nz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_text_formatter #(.LEADING_ZERO(1)) dut (
    .clk(clk), .rst(rst), .start(start), .a_val(a_val), .n_val(n_val),
    .res_val(res_val), .char_addr(char_addr), .char_data(char_data),
    .busy(busy), .buf_valid(buf_valid)
  );

  lcd_text_formatter #(.LEADING_ZERO(0)) dut_nz (
    .clk(clk), .rst(rst), .start(start), .a_val(a_val), .n_val(n_val),
    .res_val(res_val), .char_addr(char_addr), .char_data(char_data_nz),
    .busy(busy_nz), .buf_valid(buf_valid_nz)
  );

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0: leading zeros shown, index 1: leading zero blanked.
  string      tmpl0 = "A=00 N=00 R=00  ";
  string      tmpl1 = "A= 0 N= 0 R= 0  ";
  logic [7:0] mline [2][16];
  logic [7:0] mchar [2];
  logic [5:0] msnap [3];
  bit         mbusy, mvalid, mready;
  int         mphase;

  always @(posedge clk) begin
    int op;
    int val;
    int pos;
    if (rst) begin
      mready = 1'b1;
      mbusy  = 1'b0;
      mvalid = 1'b0;
      mphase = 0;
      for (int i = 0; i < 3; i++) msnap[i] = 6'd0;
      for (int p = 0; p < 16; p++) begin
        mline[0][p] = tmpl0[p];
        mline[1][p] = tmpl1[p];
      end
      mchar[0] = 8'h20;
      mchar[1] = 8'h20;
    end else if (mready) begin
      mchar[0] = mline[0][char_addr];
      mchar[1] = mline[1][char_addr];
      if (!mbusy) begin
        if (start) begin
          msnap[0] = a_val;
          msnap[1] = n_val;
          msnap[2] = res_val;
          mbusy    = 1'b1;
          mvalid   = 1'b0;
          mphase   = 0;
        end
      end else begin
        mphase++;
        if (mphase % 8 == 0) begin
          op  = mphase / 8 - 1;
          val = int'(msnap[op]);
          pos = 2 + 5 * op;
          mline[0][pos]     = 8'(48 + val / 10);
          mline[1][pos]     = (val / 10 == 0) ? 8'h20 : 8'(48 + val / 10);
          mline[0][pos + 1] = 8'(48 + val % 10);
          mline[1][pos + 1] = 8'(48 + val % 10);
        end
        if (mphase == 24) begin
          mbusy  = 1'b0;
          mvalid = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of both DUTs against the model
  always @(posedge clk) begin
    #1;
    if (mready) begin
      chk8("busy",         {7'd0, busy},         {7'd0, mbusy});
      chk8("buf_valid",    {7'd0, buf_valid},    {7'd0, mvalid});
      chk8("char_data",    char_data,            mchar[0]);
      chk8("busy_nz",      {7'd0, busy_nz},      {7'd0, mbusy});
      chk8("buf_valid_nz", {7'd0, buf_valid_nz}, {7'd0, mvalid});
      chk8("char_data_nz", char_data_nz,         mchar[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse_start(input int a, input int n, input int r);
    @(negedge clk);
    a_val   = 6'(a);
    n_val   = 6'(n);
    res_val = 6'(r);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!buf_valid && cyc < 40);
  endtask

  task automatic read_pos(input string nm, input int p, input logic [7:0] e0, input logic [7:0] e1);
    @(negedge clk);
    char_addr = 4'(p);
    @(posedge clk);
    #1;
    chk8({nm, "_lz1"}, char_data, e0);
    chk8({nm, "_lz0"}, char_data_nz, e1);
  endtask

  task automatic read_line(input string nm, input string e0, input string e1);
    for (int p = 0; p < 16; p++) read_pos(nm, p, e0[p], e1[p]);
    @(negedge clk);
    char_addr = 4'd0;
  endtask

  task automatic run(input string nm, input int a, input int n, input int r);
    int cyc;
    pulse_start(a, n, r);
    wait_valid(cyc);
    chk_int({nm, "_latency"}, cyc, 24);
  endtask

  initial begin
    int cyc;
    int pulses;
    rst = 1'b1; start = 1'b0; a_val = '0; n_val = '0; res_val = '0; char_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    read_line("reset_line", "A=00 N=00 R=00  ", "A= 0 N= 0 R= 0  ");

    run("run_2_5_32", 2, 5, 32);
    read_line("line_2_5_32", "A=02 N=05 R=32  ", "A= 2 N= 5 R=32  ");

    run("run_63_1_63", 63, 1, 63);
    read_line("line_63_1_63", "A=63 N=01 R=63  ", "A=63 N= 1 R=63  ");

    run("run_3_0_1", 3, 0, 1);
    read_line("line_3_0_1", "A=03 N=00 R=01  ", "A= 3 N= 0 R= 1  ");

    // Second start at E10 with new inputs must be ignored
    pulse_start(11, 22, 33);
    repeat (9) @(negedge clk);
    a_val = 6'd44; n_val = 6'd55; res_val = 6'd60; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(cyc);
    chk_int("ignored_start_latency", cyc, 14);
    read_line("line_ignored", "A=11 N=22 R=33  ", "A=11 N=22 R=33  ");

    // Reset at E12, mid-conversion
    pulse_start(50, 60, 13);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk8("midrst_busy", {7'd0, busy}, 8'd0);
    chk8("midrst_valid", {7'd0, buf_valid}, 8'd0);
    read_line("midrst_line", "A=00 N=00 R=00  ", "A= 0 N= 0 R= 0  ");
    run("run_after_rst", 7, 40, 9);
    read_line("line_after_rst", "A=07 N=40 R=09  ", "A= 7 N=40 R= 9  ");

    // start held high: back-to-back runs, buf_valid high one cycle between them
    @(negedge clk);
    a_val = 6'd12; n_val = 6'd34; res_val = 6'd56; start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (buf_valid) pulses++;
    end
    @(negedge clk);
    start = 1'b0;
    chk_int("held_start_pulses", pulses, 2);
    wait_valid(cyc);
    chk_int("held_start_final", {31'd0, buf_valid}, 1);
    read_line("line_held", "A=12 N=34 R=56  ", "A=12 N=34 R=56  ");

    // Sweep res over all values
    for (int r = 0; r < 64; r++) begin
      run("sweep", 0, 0, r);
      read_pos("sweep_tens", 12, 8'(48 + r / 10), (r < 10) ? 8'h20 : 8'(48 + r / 10));
      read_pos("sweep_units", 13, 8'(48 + r % 10), 8'(48 + r % 10));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
